pr_bus_arbiter: RTL and testbench
=================================

# pr_bus_arbiter

Two-master arbiter and access sequencer for the peripheral (timer) address window. It sits between the CPU's data-side bridge port (master 0) and a second bus master such as a debug/DMA port (master 1), and the two timer devices at DEV0_BASE and DEV1_BASE. It serialises one transaction at a time, decodes legal register accesses, and generates single-cycle device write strobes and registered read responses. Illegal accesses return an error response and never touch a device.

## Interface
Parameters:
- DEV0_BASE, 32'h00007f00, byte base of timer 0 (regs at +0 CTRL, +4 PRESET, +8 COUNT)
- DEV1_BASE, 32'h00007f10, byte base of timer 1 (same layout)
- WAIT_CYCLES, 1, cycles spent in ACCESS per transaction; legal range 1..15

Ports:
- Clock `clk` and reset `reset`: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low
- m0_req / m1_req  in  1  request, held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  30  word address [31:2]
- m0_wdata / m1_wdata  in  32  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  valid with ack; 1 = rejected access
- m0_rdata / m1_rdata  out  32  read data, valid with ack (0 on write or error)
- dev_addr  out  2  register offset [3:2] to both devices
- dev_wdata  out  32  write data to both devices
- dev0_we / dev1_we  out  1  one-cycle write strobe
- dev0_rdata / dev1_rdata  in  32  combinational device read data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, grant and latch that master's we/addr/wdata. One request only: grant it. Both: grant the master NOT granted last (round-robin); `last` register resets to 1 so master 0 wins the first tie.
- Decode of latched address (byte addr = {addr,2'b00}): hit = within [BASE, BASE+8] of a device. Legal read: offsets 0,4,8. Legal write: offsets 0,4 only (COUNT is read-only). Offset 0xC, any other address, or write to +8 is an error.
- Legal: IDLE -> ACCESS, 4-bit wait counter loaded with WAIT_CYCLES-1. Error: IDLE -> RESP directly, err=1, no strobe.
- ACCESS: dev_addr/dev_wdata driven from latched values for the whole state. Counter decrements each cycle; on counter==0 (final ACCESS cycle): write asserts the selected devN_we for that cycle only; read captures selected devN_rdata into the response register. Then -> RESP.
- RESP: granted master's ack=1 for exactly one cycle, with err and rdata; other master's ack/err/rdata = 0. `last` updated to granted master. -> IDLE unconditionally.
- Master dropping req mid-transaction: ignored; transaction completes and ack still pulses.
- Requests arriving during ACCESS/RESP wait; re-sampled only in IDLE.

## Timing
- Reset (async assert): state=IDLE, counter=0, last=1, all ack/err/we = 0, all rdata, dev_addr, dev_wdata = 0. Reset mid-ACCESS aborts with no write strobe; no ack is ever issued for the aborted transaction.
- Req high in cycle 0 (IDLE) -> ACCESS cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1 -> IDLE in cycle WAIT_CYCLES+2. Default: ack 2 cycles after request cycle.
- Error: ack with err=1 in cycle 1; IDLE in cycle 2.
- Write strobe in cycle WAIT_CYCLES; device sees it one cycle before ack.
- Back-to-back throughput: one transaction per WAIT_CYCLES+2 cycles; master holding req after ack is re-granted in the IDLE cycle that follows (subject to round-robin).
- All outputs are registered or decoded purely from state/latched registers; no combinational path from any m*_req to any output.

## Test plan
- m0 read 0x7f08, dev0_rdata=32'h0000_1234, WAIT_CYCLES=1 -> m0_ack in cycle 2, m0_rdata=32'h1234, m0_err=0, no we strobe.
- m1 write 0x7f14 data 32'hA5A5 -> dev1_we high exactly in cycle 1, dev_addr=2'b01, dev_wdata=32'hA5A5, m1_ack cycle 2, dev0_we never high.
- Both masters request continuously after reset -> grants alternate m0, m1, m0, m1; each ack 3 cycles apart; other master's ack stays 0.
- m0 write 0x7f08, then m0 read 0x7f20 -> each acked with err=1 one cycle after sampling, rdata=0, no device strobe.
- WAIT_CYCLES=3, m0 write 0x7f00 -> dev0_we in cycle 3 only, ack in cycle 4; reset asserted in cycle 2 -> no strobe, no ack, all outputs 0 immediately.
- m0 drops req in cycle 1 of a legal write -> strobe and ack still occur on schedule; next IDLE idles with no grant.

Source files
------------

// File: rtl/pr_bus_arbiter.sv
// rtl/pr_bus_arbiter.sv - two-master round-robin arbiter and access sequencer for the timer window
// One transaction at a time: IDLE grants and decodes, ACCESS waits and strobes, RESP acks.
module pr_bus_arbiter #(
  parameter logic [31:0] DEV0_BASE   = 32'h00007f00,
  parameter logic [31:0] DEV1_BASE   = 32'h00007f10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rdata,
  input  logic [31:0] dev1_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last;
  logic        gnt;
  logic        l_we;
  logic        l_sel;
  logic [1:0]  l_off;
  logic [31:0] l_wdata;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        pick;
  logic        s_we;
  logic [29:0] s_addr;
  logic [31:0] s_wdata;
  logic [29:0] woff0;
  logic [29:0] woff1;
  logic        hit0;
  logic        hit1;
  logic        s_sel;
  logic [1:0]  s_off;
  logic        s_legal;

  // Word offsets from each base; unsigned wrap makes below-base addresses miss.
  always_comb begin
    pick    = (m0_req && m1_req) ? ~last : m1_req;
    s_we    = pick ? m1_we : m0_we;
    s_addr  = pick ? m1_addr : m0_addr;
    s_wdata = pick ? m1_wdata : m0_wdata;
    woff0   = s_addr - DEV0_BASE[31:2];
    woff1   = s_addr - DEV1_BASE[31:2];
    hit0    = woff0 < 30'd3;
    hit1    = woff1 < 30'd3;
    s_sel   = !hit0;
    s_off   = hit0 ? woff0[1:0] : woff1[1:0];
    s_legal = (hit0 || hit1) && !(s_we && s_off == 2'd2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      gnt     <= 1'b0;
      l_we    <= 1'b0;
      l_sel   <= 1'b0;
      l_off   <= 2'd0;
      l_wdata <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt     <= pick;
            l_we    <= s_we;
            l_sel   <= s_sel;
            l_off   <= s_off;
            l_wdata <= s_wdata;
            rdata_r <= 32'd0;
            if (s_legal) begin
              err_r <= 1'b0;
              cnt   <= WAIT_LOAD;
              state <= ACCESS;
            end else begin
              err_r <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!l_we) rdata_r <= l_sel ? dev1_rdata : dev0_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic final_access;
  assign final_access = (state == ACCESS) && (cnt == 4'd0);

  assign dev0_we   = final_access && l_we && !l_sel;
  assign dev1_we   = final_access && l_we && l_sel;
  assign dev_addr  = l_off;
  assign dev_wdata = l_wdata;

  assign m0_ack   = (state == RESP) && !gnt;
  assign m1_ack   = (state == RESP) && gnt;
  assign m0_err   = m0_ack && err_r;
  assign m1_err   = m1_ack && err_r;
  assign m0_rdata = m0_ack ? rdata_r : 32'd0;
  assign m1_rdata = m1_ack ? rdata_r : 32'd0;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb/tb_pr_bus_arbiter.sv - randomized transaction-level check of pr_bus_arbiter plus directed WAIT_CYCLES=3 cases
module tb_pr_bus_arbiter;

  localparam int W = 1;
  localparam logic [31:0] D0 = 32'h00007f00;
  localparam logic [31:0] D1 = 32'h00007f10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        m0_req, m1_req, m0_we, m1_we, m0_ack, m1_ack, m0_err, m1_err, dev0_we, dev1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, dev_wdata, dev0_rdata, dev1_rdata;
  logic [1:0]  dev_addr;

  logic        b_m0_req, b_m1_req, b_m0_we, b_m1_we, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_dev0_we, b_dev1_we;
  logic [29:0] b_m0_addr, b_m1_addr;
  logic [31:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_dev_wdata, b_dev0_rdata, b_dev1_rdata;
  logic [1:0]  b_dev_addr;

  pr_bus_arbiter #(.DEV0_BASE(D0), .DEV1_BASE(D1), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev0_we(dev0_we), .dev1_we(dev1_we),
    .dev0_rdata(dev0_rdata), .dev1_rdata(dev1_rdata)
  );

  pr_bus_arbiter #(.DEV0_BASE(D0), .DEV1_BASE(D1), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_err(b_m0_err), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_err(b_m1_err), .m1_rdata(b_m1_rdata),
    .dev_addr(b_dev_addr), .dev_wdata(b_dev_wdata), .dev0_we(b_dev0_we), .dev1_we(b_dev1_we),
    .dev0_rdata(b_dev0_rdata), .dev1_rdata(b_dev1_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction schedule in absolute cycle numbers.
  int          cyc, idle_at, t_ack, t_acc0, t_acc1;
  bit          mlast, act, g, t_we, t_err, t_dev;
  logic [1:0]  t_off;
  logic [31:0] t_wdata, t_rdata;
  bit          pend [2];
  bit          p_we [2];
  logic [29:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [31:0] pool [10] = '{32'h7f00, 32'h7f04, 32'h7f08, 32'h7f0c, 32'h7f10,
                             32'h7f14, 32'h7f18, 32'h7f1c, 32'h7f20, 32'h7efc};

  task automatic decode(input logic [31:0] b, input bit we, output bit legal,
                        output bit dev, output logic [1:0] off);
    logic [31:0] base;
    legal = 1'b0; dev = 1'b0; off = 2'd0;
    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? D0 : D1;
      for (int r = 0; r < 3; r++) begin
        if (b == base + 32'(4 * r)) begin
          dev   = (d == 1);
          off   = 2'(r);
          legal = !(we && r == 2);
        end
      end
    end
  endtask

  task automatic model_reset();
    act = 1'b0; mlast = 1'b1; idle_at = cyc;
    pend[0] = 1'b0; pend[1] = 1'b0;
  endtask

  task automatic cycle_check();
    bit a0, a1, in_acc, wstb;
    a0     = act && cyc == t_ack && !g;
    a1     = act && cyc == t_ack && g;
    in_acc = act && !t_err && cyc >= t_acc0 && cyc <= t_acc1;
    wstb   = act && !t_err && t_we && cyc == t_acc1;
    chk("m0_ack", m0_ack, a0);
    chk("m1_ack", m1_ack, a1);
    chk("m0_err", m0_err, a0 && t_err);
    chk("m1_err", m1_err, a1 && t_err);
    chk("m0_rdata", m0_rdata, a0 ? t_rdata : 32'd0);
    chk("m1_rdata", m1_rdata, a1 ? t_rdata : 32'd0);
    chk("dev0_we", dev0_we, wstb && !t_dev);
    chk("dev1_we", dev1_we, wstb && t_dev);
    if (in_acc) begin
      chk("dev_addr", dev_addr, t_off);
      chk("dev_wdata", dev_wdata, t_wdata);
    end
    if (act && cyc == t_ack) begin
      act = 1'b0; mlast = g; pend[g] = 1'b0;
    end
  endtask

  task automatic drive();
    logic [31:0] b;
    bit rq [2];
    bit legal, dev;
    logic [1:0] off;
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 3) != 0) begin
        pend[i] = 1'b1;
        p_we[i] = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 10);
        b = (k == 10) ? $urandom : pool[k];
        p_addr[i]  = b[31:2];
        p_wdata[i] = $urandom;
      end
      rq[i] = pend[i] && !(act && g == 1'(i) && $urandom_range(0, 2) == 0);
    end
    m0_req   = rq[0];
    m0_we    = p_we[0];
    m0_addr  = rq[0] ? p_addr[0] : 30'($urandom);
    m0_wdata = rq[0] ? p_wdata[0] : $urandom;
    m1_req   = rq[1];
    m1_we    = p_we[1];
    m1_addr  = rq[1] ? p_addr[1] : 30'($urandom);
    m1_wdata = rq[1] ? p_wdata[1] : $urandom;
    dev0_rdata = $urandom;
    dev1_rdata = $urandom;
    if (act && !t_err && !t_we && cyc == t_acc1) t_rdata = t_dev ? dev1_rdata : dev0_rdata;
    if (!act && cyc >= idle_at && (rq[0] || rq[1])) begin
      g = (rq[0] && rq[1]) ? !mlast : rq[1];
      decode({p_addr[g], 2'b00}, p_we[g], legal, dev, off);
      act = 1'b1; t_we = p_we[g]; t_err = !legal; t_dev = dev; t_off = off;
      t_wdata = p_wdata[g]; t_rdata = 32'd0;
      if (legal) begin
        t_acc0 = cyc + 1; t_acc1 = cyc + W; t_ack = cyc + W + 1;
      end else begin
        t_acc0 = -10; t_acc1 = -10; t_ack = cyc + 1;
      end
      idle_at = t_ack + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cycle_check();
    drive();
  endtask

  task automatic chk_b_idle(input string tag);
    chk({tag, "_b_m0_ack"}, b_m0_ack, 1'b0);
    chk({tag, "_b_m1_ack"}, b_m1_ack, 1'b0);
    chk({tag, "_b_dev0_we"}, b_dev0_we, 1'b0);
    chk({tag, "_b_dev1_we"}, b_dev1_we, 1'b0);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    dev0_rdata = 0; dev1_rdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0; b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0;
    b_m1_wdata = 0; b_dev0_rdata = 32'h1111_2222; b_dev1_rdata = 32'h3333_4444;
    #12;
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_dev_addr", dev_addr, 2'd0);
    chk("rst_dev_wdata", dev_wdata, 32'd0);
    chk("rst_dev0_we", dev0_we, 1'b0);
    chk("rst_dev1_we", dev1_we, 1'b0);
    chk_b_idle("rst");
    @(negedge clk);
    reset = 1'b1;

    // WAIT_CYCLES=3 write to timer0 CTRL; master drops req in cycle 1.
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 30'(D0 >> 2); b_m0_wdata = 32'hCAFE_0001;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) b_m0_req = 1'b0;
      chk($sformatf("w3_dev0_we_c%0d", c), b_dev0_we, c == 3);
      chk($sformatf("w3_dev1_we_c%0d", c), b_dev1_we, 1'b0);
      chk($sformatf("w3_m0_ack_c%0d", c), b_m0_ack, c == 4);
      chk($sformatf("w3_m1_ack_c%0d", c), b_m1_ack, 1'b0);
      chk($sformatf("w3_m0_err_c%0d", c), b_m0_err, 1'b0);
      chk($sformatf("w3_m0_rdata_c%0d", c), b_m0_rdata, 32'd0);
      if (c <= 3) begin
        chk($sformatf("w3_dev_addr_c%0d", c), b_dev_addr, 2'd0);
        chk($sformatf("w3_dev_wdata_c%0d", c), b_dev_wdata, 32'hCAFE_0001);
      end
    end

    // Randomized two-master traffic against the schedule model.
    cyc = 0;
    model_reset();
    drive();
    repeat (400) step();

    // Reset asserted during the strobe cycle of a legal write.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (act && !t_err && t_we && cyc == t_acc1) found = 1'b1;
    end
    chk("rst_mid_found", found, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_dev0_we", dev0_we, 1'b0);
    chk("rst_mid_dev1_we", dev1_we, 1'b0);
    chk("rst_mid_m0_ack", m0_ack, 1'b0);
    chk("rst_mid_m1_ack", m1_ack, 1'b0);
    chk("rst_mid_dev_addr", dev_addr, 2'd0);
    chk("rst_mid_dev_wdata", dev_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive();
    repeat (300) step();

    // WAIT_CYCLES=3 write aborted by reset in cycle 2: no strobe, no ack.
    m0_req = 1'b0; m1_req = 1'b0;
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 30'((D0 + 32'd4) >> 2); b_m0_wdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk);
      #1;
      chk_b_idle($sformatf("ab_c%0d", c));
    end
    b_m0_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_b_idle("ab_rst");
    chk("ab_rst_dev_wdata", b_dev_wdata, 32'd0);
    chk("ab_rst_dev_addr", b_dev_addr, 2'd0);
    chk("ab_rst_m0_rdata", b_m0_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk_b_idle($sformatf("ab_post%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
